// File: rtl/imem_arbiter_pkg.sv
// Shared types and helpers for the instruction-memory arbiter: data widths, response owner
// encoding and the address checks used by both request ports.
package imem_arbiter_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnDbg  = 2'd2
  } owner_e;

  // Word-address width for a byte-sized memory.
  function automatic int unsigned word_addr_width(input int unsigned mem_size);
    return $clog2(mem_size / 4);
  endfunction

  // Misaligned or out-of-range byte addresses never reach the RAM.
  function automatic logic addr_err(input logic [XLEN-1:0] addr, input int unsigned mem_size);
    return (addr[1:0] != 2'b00) || (addr >= XLEN'(mem_size));
  endfunction

endpackage

// File: rtl/imem_arb_grant.sv
// Two-way grant for a shared single-port memory: fixed debug-over-fetch priority, or
// round-robin on conflicts when IMEM_ARB_RR_EN is defined.
module imem_arb_grant (
  input  logic clk,
  input  logic rst_n,
  input  logic req_if,
  input  logic req_dbg,
  output logic gnt_if,
  output logic gnt_dbg
);

`ifdef IMEM_ARB_RR_EN
  // Remembers which side won the most recent conflict; starts as if fetch had won.
  logic last_dbg_q, last_dbg_d;
  logic conflict;

  assign conflict = req_if & req_dbg;

  always_comb begin
    gnt_dbg    = req_dbg & (~req_if | ~last_dbg_q);
    gnt_if     = req_if & (~req_dbg | last_dbg_q);
    last_dbg_d = last_dbg_q;
    if (conflict) begin
      last_dbg_d = gnt_dbg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dbg_q <= 1'b0;
    end else begin
      last_dbg_q <= last_dbg_d;
    end
  end
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    gnt_dbg = req_dbg;
    gnt_if  = req_if & ~req_dbg;
  end
`endif

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the synchronous-read instruction RAM between fetch and the debug port, with a
// one-stage response pipeline. Define IMEM_ARB_RR_EN for round-robin conflict resolution.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned  MEM_SIZE   = 8192,
  localparam int unsigned ADDR_WIDTH = word_addr_width(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [XLEN-1:0]       if_req_addr,
  output logic                  if_rsp_valid,
  output logic [ILEN-1:0]       if_rsp_inst,
  output logic                  if_rsp_err,

  input  logic                  dbg_req_valid,
  output logic                  dbg_req_ready,
  input  logic                  dbg_req_we,
  input  logic [XLEN-1:0]       dbg_req_addr,
  input  logic [31:0]           dbg_req_wdata,
  output logic                  dbg_rsp_valid,
  output logic [31:0]           dbg_rsp_rdata,
  output logic                  dbg_rsp_err,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  logic   if_req, dbg_req;
  logic   gnt_if, gnt_dbg;
  logic   if_err, dbg_err;
  owner_e owner_d, owner_q;
  logic   err_d, err_q;
  logic   we_d, we_q;

  // Requests are masked while reset is held so ready and RAM strobes stay low.
  assign if_req  = if_req_valid & rst_n;
  assign dbg_req = dbg_req_valid & rst_n;
  assign if_err  = addr_err(if_req_addr, MEM_SIZE);
  assign dbg_err = addr_err(dbg_req_addr, MEM_SIZE);

  imem_arb_grant u_grant (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_if  (if_req),
    .req_dbg (dbg_req),
    .gnt_if  (gnt_if),
    .gnt_dbg (gnt_dbg)
  );

  always_comb begin
    if_req_ready  = gnt_if;
    dbg_req_ready = gnt_dbg;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    owner_d       = OwnNone;
    err_d         = 1'b0;
    we_d          = 1'b0;
    if (gnt_dbg) begin
      mem_en    = ~dbg_err;
      mem_we    = ~dbg_err & dbg_req_we;
      mem_addr  = dbg_req_addr[ADDR_WIDTH+1:2];
      mem_wdata = dbg_req_wdata;
      owner_d   = OwnDbg;
      err_d     = dbg_err;
      we_d      = dbg_req_we;
    end else if (gnt_if) begin
      mem_en   = ~if_err;
      mem_addr = if_req_addr[ADDR_WIDTH+1:2];
      owner_d  = OwnIf;
      err_d    = if_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OwnNone;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
      we_q    <= we_d;
    end
  end

  // Data is only forwarded for good reads; everything else returns zero.
  always_comb begin
    if_rsp_valid  = (owner_q == OwnIf);
    if_rsp_err    = if_rsp_valid & err_q;
    if_rsp_inst   = '0;
    dbg_rsp_valid = (owner_q == OwnDbg);
    dbg_rsp_err   = dbg_rsp_valid & err_q;
    dbg_rsp_rdata = '0;
    if (if_rsp_valid && !err_q) begin
      if_rsp_inst = mem_rdata;
    end
    if (dbg_rsp_valid && !err_q && !we_q) begin
      dbg_rsp_rdata = mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized scoreboard bench for imem_arbiter with a behavioural RAM and reference model.
module tb_imem_arbiter;

  localparam int unsigned MEM_SIZE = 8192;
  localparam int          AW       = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req_valid = 1'b0, if_req_ready;
  logic [31:0]   if_req_addr = '0;
  logic          if_rsp_valid, if_rsp_err;
  logic [31:0]   if_rsp_inst;
  logic          dbg_req_valid = 1'b0, dbg_req_ready, dbg_req_we = 1'b0;
  logic [31:0]   dbg_req_addr = '0, dbg_req_wdata = '0;
  logic          dbg_rsp_valid, dbg_rsp_err;
  logic [31:0]   dbg_rsp_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  imem_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_inst   (if_rsp_inst),
    .if_rsp_err    (if_rsp_err),
    .dbg_req_valid (dbg_req_valid),
    .dbg_req_ready (dbg_req_ready),
    .dbg_req_we    (dbg_req_we),
    .dbg_req_addr  (dbg_req_addr),
    .dbg_req_wdata (dbg_req_wdata),
    .dbg_rsp_valid (dbg_rsp_valid),
    .dbg_rsp_rdata (dbg_rsp_rdata),
    .dbg_rsp_err   (dbg_rsp_err),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous RAM with a bench-side preload port.
  logic [31:0]   ram [2048];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_data = '0;
  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    bit          is_dbg;
    bit          err;
    logic [31:0] data;
    int          stamp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [2048];
  bit          rr_last_dbg = 1'b0;
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ref_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= MEM_SIZE);
  endfunction

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 99);
    if (r < 75) return 32'($urandom_range(0, 31)) * 4;
    if (r < 83) return MEM_SIZE - 4;
    if (r < 88) return MEM_SIZE;
    if (r < 94) return 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
    return $urandom;
  endfunction

  task automatic preload(input int w, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = AW'(w);
    ld_data = d;
    ref_mem[w] = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Present one cycle of requests, check arbitration against the model, queue responses.
  task automatic step(input bit iv, input logic [31:0] ia, input bit dv, input bit dwe,
                      input logic [31:0] da, input logic [31:0] dwd,
                      output bit gi, output bit gd);
    exp_t e;
    bit   ie, de;
    if_req_valid  = iv;
    if_req_addr   = ia;
    dbg_req_valid = dv;
    dbg_req_we    = dwe;
    dbg_req_addr  = da;
    dbg_req_wdata = dwd;
    #1;
    ie = ref_err(ia);
    de = ref_err(da);
    if (iv && dv) begin
`ifdef IMEM_ARB_RR_EN
      gd = !rr_last_dbg;
      rr_last_dbg = gd;
`else
      gd = 1'b1;
`endif
      gi = !gd;
    end else begin
      gi = iv;
      gd = dv;
    end
    chk("if_req_ready", 32'(if_req_ready), 32'(gi));
    chk("dbg_req_ready", 32'(dbg_req_ready), 32'(gd));
    chk("mem_en", 32'(mem_en), 32'((gi && !ie) || (gd && !de)));
    if (gd && !de) begin
      chk("mem_we", 32'(mem_we), 32'(dwe));
      chk("mem_addr", 32'(mem_addr), 32'(da[12:2]));
      if (dwe) chk("mem_wdata", mem_wdata, dwd);
    end else if (gi && !ie) begin
      chk("mem_we", 32'(mem_we), 32'd0);
      chk("mem_addr", 32'(mem_addr), 32'(ia[12:2]));
    end
    e.stamp = cyc;
    if (gd) begin
      e.is_dbg = 1'b1;
      e.err    = de;
      e.data   = (de || dwe) ? 32'd0 : ref_mem[da[12:2]];
      if (!de && dwe) ref_mem[da[12:2]] = dwd;
      sb.push_back(e);
    end else if (gi) begin
      e.is_dbg = 1'b0;
      e.err    = ie;
      e.data   = ie ? 32'd0 : ref_mem[ia[12:2]];
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_ready"}, 32'(if_req_ready), 32'd0);
    chk({tag, "_dbg_ready"}, 32'(dbg_req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'({if_rsp_valid, dbg_rsp_valid}), 32'd0);
    chk({tag, "_rsp_err"}, 32'({if_rsp_err, dbg_rsp_err}), 32'd0);
    chk({tag, "_if_inst"}, if_rsp_inst, 32'd0);
    chk({tag, "_dbg_rdata"}, dbg_rsp_rdata, 32'd0);
    chk({tag, "_mem_ctl"}, 32'({mem_en, mem_we}), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever a response strobe is seen.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sb.size() > 0 && sb[0].stamp < cyc - 1) begin
          n_tests++;
          n_fail++;
          $display("FAIL missing_rsp: got no response, expected one for request at cycle %0d",
                   sb[0].stamp);
          void'(sb.pop_front());
        end
        if (if_rsp_valid || dbg_rsp_valid) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: got if=%0b dbg=%0b, expected none (cycle %0d)",
                     if_rsp_valid, dbg_rsp_valid, cyc);
          end else begin
            e = sb.pop_front();
            chk("rsp_latency", 32'(cyc - e.stamp), 32'd1);
            chk("rsp_owner", 32'({dbg_rsp_valid, if_rsp_valid}), e.is_dbg ? 32'd2 : 32'd1);
            if (e.is_dbg) begin
              chk("dbg_rsp_err", 32'(dbg_rsp_err), 32'(e.err));
              chk("dbg_rsp_rdata", dbg_rsp_rdata, e.data);
            end else begin
              chk("if_rsp_err", 32'(if_rsp_err), 32'(e.err));
              chk("if_rsp_inst", if_rsp_inst, e.data);
            end
          end
        end else begin
          chk("idle_rsp_data", if_rsp_inst | dbg_rsp_rdata, 32'd0);
          chk("idle_rsp_err", 32'({if_rsp_err, dbg_rsp_err}), 32'd0);
        end
      end
    end
  end

  initial begin
    bit          gi, gd, ip, dp, dwe;
    logic [31:0] ia, da, dwd;
    ip = 1'b0;
    dp = 1'b0;
    dwe = 1'b0;
    ia = '0;
    da = '0;
    dwd = '0;

    // Preload while reset is held.
    @(posedge clk); #1;
    preload(0, 32'h13);
    preload(1, 32'h93);
    preload(2, 32'h113);
    for (int w = 3; w < 32; w++) preload(w, $urandom);
    preload(2047, $urandom);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Fetch alone, back to back.
    step(1, 32'h0, 0, 0, 0, 0, gi, gd);
    step(1, 32'h4, 0, 0, 0, 0, gi, gd);
    step(1, 32'h8, 0, 0, 0, 0, gi, gd);
    // Debug write then fetch of the same word.
    step(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, gi, gd);
    step(1, 32'h40, 0, 0, 0, 0, gi, gd);
    // Three-cycle conflict.
    for (int i = 0; i < 3; i++) step(1, 32'h4, 1, 0, 32'h8, 0, gi, gd);
    // Error accesses and the address boundary.
    step(1, 32'h2, 0, 0, 0, 0, gi, gd);
    step(0, 0, 1, 0, 32'h2000, 0, gi, gd);
    step(1, MEM_SIZE - 4, 0, 0, 0, 0, gi, gd);
    step(0, 0, 1, 0, MEM_SIZE - 4, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, gi, gd);

    // Reset the cycle after a fetch accept: the response must be dropped.
    step(1, 32'h4, 0, 0, 0, 0, gi, gd);
    rst_n = 1'b0;
    sb.delete();
    rr_last_dbg = 1'b0;
    if_req_valid = 1'b1;
    dbg_req_valid = 1'b1;
    dbg_req_addr = 32'h8;
    #1;
    chk_all_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    if_req_valid = 1'b0;
    dbg_req_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, gi, gd);

    // Randomized traffic; an unaccepted request is held until granted.
    for (int i = 0; i < 600; i++) begin
      if (!ip && $urandom_range(0, 99) < 60) begin
        ip = 1'b1;
        ia = rand_addr();
      end
      if (!dp && $urandom_range(0, 99) < 45) begin
        dp  = 1'b1;
        da  = rand_addr();
        dwe = 1'($urandom_range(0, 1));
        dwd = $urandom;
      end
      step(ip, ia, dp, dwe, da, dwd, gi, gd);
      if (gi) ip = 1'b0;
      if (gd) dp = 1'b0;
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, gi, gd);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
